// File: rtl/bus_access_tracer.sv
// rtl/bus_access_tracer.sv - passive CPU/memory bus monitor with trace FIFO, counters and sticky flags
module bus_access_tracer #(
    parameter int N     = 16,
    parameter int A     = 16,
    parameter int DEPTH = 8,
    parameter int LIMIT = 4096
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [A-1:0]               Address,
    input  logic                       RW,
    input  logic [N-1:0]               wdata,
    input  logic [N-1:0]               rdata,
    input  logic                       en,
    input  logic                       clear,
    input  logic                       pop,
    output logic                       entry_valid,
    output logic                       entry_rw,
    output logic [A-1:0]               entry_addr,
    output logic [N-1:0]               entry_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic [7:0]                 ld_count,
    output logic [7:0]                 st_count,
    output logic                       overflow,
    output logic                       range_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL    = LW'(DEPTH);
    localparam logic [A:0]    LIMIT_W = (A+1)'(LIMIT);

    typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;

    state_t         state;
    logic [A-1:0]   prev_addr;
    logic           prev_rw;
    logic           cap_rw;
    logic [A-1:0]   cap_addr;
    logic [N-1:0]   cap_data;

    logic           fifo_rw   [DEPTH];
    logic [A-1:0]   fifo_addr [DEPTH];
    logic [N-1:0]   fifo_data [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [LW-1:0]  count;

    logic           start;
    logic           push;
    logic           full;
    logic           do_pop;
    logic           do_write;
    logic           drop;
    logic           out_of_range;
    logic [N-1:0]   push_data;

    // A new access is any enabled cycle that leaves IDLE or changes address/direction
    assign start        = en && (state == IDLE || Address != prev_addr || RW != prev_rw);
    assign push         = (state == CAPTURE);
    assign full         = (count == FULL);
    assign do_pop       = pop && (count != '0);
    assign do_write     = push && (!full || do_pop);
    assign drop         = push && full && !do_pop;
    assign out_of_range = ({1'b0, Address} >= LIMIT_W);
    // Reads take the memory's data one cycle after the start; writes use the latched CPU data
    assign push_data    = cap_rw ? rdata : cap_data;

    // Access detection FSM plus previous-cycle bus shadow and start-time capture latch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            prev_addr <= '0;
            prev_rw   <= 1'b1;
            cap_rw    <= 1'b0;
            cap_addr  <= '0;
            cap_data  <= '0;
        end else begin
            prev_addr <= Address;
            prev_rw   <= RW;
            if (!en)
                state <= IDLE;
            else if (start)
                state <= CAPTURE;
            else if (state == CAPTURE)
                state <= HOLD;
            if (start) begin
                cap_rw   <= RW;
                cap_addr <= Address;
                if (!RW)
                    cap_data <= wdata;
            end
        end
    end

    // Saturating access counters and sticky flags; clear has priority over any update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_count  <= '0;
            st_count  <= '0;
            overflow  <= 1'b0;
            range_err <= 1'b0;
        end else if (clear) begin
            ld_count  <= '0;
            st_count  <= '0;
            overflow  <= 1'b0;
            range_err <= 1'b0;
        end else begin
            if (start && RW && ld_count != 8'hFF)
                ld_count <= ld_count + 8'd1;
            if (start && !RW && st_count != 8'hFF)
                st_count <= st_count + 8'd1;
            if (start && out_of_range)
                range_err <= 1'b1;
            if (drop)
                overflow <= 1'b1;
        end
    end

    // Trace storage; contents need no reset because the head is masked while empty
    always_ff @(posedge clk) begin
        if (do_write) begin
            fifo_rw[wr_ptr]   <= cap_rw;
            fifo_addr[wr_ptr] <= cap_addr;
            fifo_data[wr_ptr] <= push_data;
        end
    end

    // FIFO pointers and occupancy; push+pop at full keeps the level at DEPTH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_write, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign level       = count;
    assign entry_valid = (count != '0);
    assign entry_rw    = entry_valid ? fifo_rw[rd_ptr]   : 1'b0;
    assign entry_addr  = entry_valid ? fifo_addr[rd_ptr] : '0;
    assign entry_data  = entry_valid ? fifo_data[rd_ptr] : '0;

endmodule

// File: tb/tb_bus_access_tracer.sv
// tb/tb_bus_access_tracer.sv - self-checking bench for bus_access_tracer
module tb_bus_access_tracer;

    localparam int N     = 16;
    localparam int A     = 16;
    localparam int DEPTH = 8;
    localparam int LIMIT = 4096;

    logic         clk = 1'b0;
    logic         reset;
    logic [A-1:0] Address;
    logic         RW;
    logic [N-1:0] wdata;
    logic [N-1:0] rdata;
    logic         en;
    logic         clear;
    logic         pop;
    logic         entry_valid;
    logic         entry_rw;
    logic [A-1:0] entry_addr;
    logic [N-1:0] entry_data;
    logic [3:0]   level;
    logic [7:0]   ld_count;
    logic [7:0]   st_count;
    logic         overflow;
    logic         range_err;

    bus_access_tracer #(.N(N), .A(A), .DEPTH(DEPTH), .LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset), .Address(Address), .RW(RW), .wdata(wdata),
        .rdata(rdata), .en(en), .clear(clear), .pop(pop),
        .entry_valid(entry_valid), .entry_rw(entry_rw), .entry_addr(entry_addr),
        .entry_data(entry_data), .level(level), .ld_count(ld_count),
        .st_count(st_count), .overflow(overflow), .range_err(range_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        rw;
        logic [15:0] addr;
        logic [15:0] data;
    } ent_t;

    // Reference model: trace queue, counters, flags, and the pending access awaiting its push
    ent_t        mq[$];
    int          m_ld, m_st;
    bit          m_ovf, m_rng;
    bit          m_pend;
    ent_t        m_pe;
    logic [15:0] m_pa;
    bit          m_prw;
    bit          m_en_prev;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ld = 0; m_st = 0; m_ovf = 0; m_rng = 0;
        m_pend = 0; m_pe = '0;
        m_pa = '0; m_prw = 1; m_en_prev = 0;
    endtask

    task automatic model_step();
        bit   st;
        ent_t e;
        st = en && (!m_en_prev || Address != m_pa || RW != m_prw);
        if (pop && mq.size() > 0)
            void'(mq.pop_front());
        if (m_pend) begin
            e = m_pe;
            if (e.rw) e.data = rdata;
            if (mq.size() < DEPTH) mq.push_back(e);
            else m_ovf = 1;
        end
        if (st) begin
            if (RW) begin if (m_ld < 255) m_ld++; end
            else    begin if (m_st < 255) m_st++; end
            if (int'(Address) >= LIMIT) m_rng = 1;
        end
        if (clear) begin
            m_ld = 0; m_st = 0; m_ovf = 0; m_rng = 0;
        end
        m_pend = st;
        m_pe   = '{rw: RW, addr: Address, data: wdata};
        m_pa = Address; m_prw = RW; m_en_prev = en;
    endtask

    task automatic model_check();
        ent_t h;
        h = (mq.size() > 0) ? mq[0] : '0;
        chk("m_valid", entry_valid, mq.size() > 0);
        chk("m_level", level, mq.size());
        chk("m_rw",    entry_rw, h.rw);
        chk("m_addr",  entry_addr, h.addr);
        chk("m_data",  entry_data, h.data);
        chk("m_ld",    ld_count, m_ld);
        chk("m_st",    st_count, m_st);
        chk("m_ovf",   overflow, m_ovf);
        chk("m_rng",   range_err, m_rng);
    endtask

    // Called at a negedge: drive, clock once, step the model, check, return at the next negedge
    task automatic cyc(input logic e, input logic [15:0] a, input logic rw,
                       input logic [15:0] wd, input logic [15:0] rd,
                       input logic p, input logic c);
        en = e; Address = a; RW = rw; wdata = wd; rdata = rd; pop = p; clear = c;
        @(posedge clk);
        model_step();
        #1;
        model_check();
        @(negedge clk);
    endtask

    typedef struct packed {
        logic        en;
        logic [15:0] a;
        logic        rw;
        logic [15:0] wd;
        logic [15:0] rd;
        logic        pop;
        logic        clr;
        logic        ev;
        logic [3:0]  lvl;
        logic        erw;
        logic [15:0] ea;
        logic [15:0] ed;
        logic [7:0]  ld;
        logic [7:0]  st;
    } vec_t;

    vec_t tv[10];
    logic [15:0] addr_pool[5];

    initial begin
        tv[0] = '{1'b1, 16'h0010, 1'b0, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 16'h0000, 8'd0, 8'd1};
        tv[1] = '{1'b1, 16'h0010, 1'b0, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 16'h0010, 16'hBEEF, 8'd0, 8'd1};
        tv[2] = '{1'b1, 16'h0010, 1'b0, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 16'h0010, 16'hBEEF, 8'd0, 8'd1};
        tv[3] = '{1'b1, 16'h0020, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 16'h0000, 8'd1, 8'd1};
        tv[4] = '{1'b1, 16'h0020, 1'b1, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 16'h0020, 16'h1234, 8'd1, 8'd1};
        tv[5] = '{1'b1, 16'h0020, 1'b1, 16'h0000, 16'h5555, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 16'h0020, 16'h1234, 8'd1, 8'd1};
        tv[6] = '{1'b1, 16'h0001, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 16'h0000, 8'd2, 8'd1};
        tv[7] = '{1'b1, 16'h0002, 1'b1, 16'h0000, 16'hA001, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 16'h0001, 16'hA001, 8'd3, 8'd1};
        tv[8] = '{1'b1, 16'h0003, 1'b1, 16'h0000, 16'hA002, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 16'h0001, 16'hA001, 8'd4, 8'd1};
        tv[9] = '{1'b1, 16'h0003, 1'b1, 16'h0000, 16'hA003, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 16'h0001, 16'hA001, 8'd4, 8'd1};
        addr_pool[0] = 16'h0010; addr_pool[1] = 16'h0011; addr_pool[2] = 16'h0FFF;
        addr_pool[3] = 16'h1000; addr_pool[4] = 16'hFFFF;

        reset = 1'b0; en = 1'b0; Address = '0; RW = 1'b0;
        wdata = '0; rdata = '0; clear = 1'b0; pop = 1'b0;
        model_reset();
        #1;
        chk("rst_valid", entry_valid, 1'b0);
        chk("rst_level", level, 4'd0);
        chk("rst_ld", ld_count, 8'd0);
        chk("rst_st", st_count, 8'd0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_rng", range_err, 1'b0);
        chk("rst_addr", entry_addr, 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Single store, single load, back-to-back reads
        for (int i = 0; i < 10; i++) begin
            cyc(tv[i].en, tv[i].a, tv[i].rw, tv[i].wd, tv[i].rd, tv[i].pop, tv[i].clr);
            chk($sformatf("v%0d_valid", i), entry_valid, tv[i].ev);
            chk($sformatf("v%0d_level", i), level, tv[i].lvl);
            chk($sformatf("v%0d_rw", i), entry_rw, tv[i].erw);
            chk($sformatf("v%0d_addr", i), entry_addr, tv[i].ea);
            chk($sformatf("v%0d_data", i), entry_data, tv[i].ed);
            chk($sformatf("v%0d_ld", i), ld_count, tv[i].ld);
            chk($sformatf("v%0d_st", i), st_count, tv[i].st);
        end

        // Overflow: drain, then DEPTH+2 starts with no pop
        repeat (3) cyc(1, 16'h0003, 1, 0, 0, 1, 0);
        chk("drain_level", level, 4'd0);
        for (int i = 0; i < DEPTH + 2; i++)
            cyc(1, 16'h0100 + 16'(i), 1, 0, 16'hC000 + 16'(i), 0, 0);
        cyc(1, 16'h0109, 1, 0, 16'hC00A, 0, 0);
        chk("full_level", level, 4'd8);
        chk("full_ovf", overflow, 1'b1);
        chk("full_head", entry_addr, 16'h0100);
        chk("full_head_data", entry_data, 16'hC001);
        cyc(1, 16'h0109, 1, 0, 0, 0, 1);
        chk("clr_ovf", overflow, 1'b0);
        chk("clr_keep_level", level, 4'd8);
        cyc(1, 16'h0200, 1, 0, 0, 0, 0);
        cyc(1, 16'h0200, 1, 0, 16'hD000, 1, 0);
        chk("pp_full_level", level, 4'd8);
        chk("pp_full_ovf", overflow, 1'b0);
        chk("pp_full_head", entry_addr, 16'h0101);

        // Range error and clear
        repeat (8) cyc(1, 16'h0200, 1, 0, 0, 1, 0);
        chk("drain2_level", level, 4'd0);
        cyc(1, 16'h1000, 1, 0, 0, 0, 0);
        chk("rng_set", range_err, 1'b1);
        cyc(1, 16'h1000, 1, 0, 16'h7777, 0, 0);
        chk("rng_logged_addr", entry_addr, 16'h1000);
        chk("rng_logged_data", entry_data, 16'h7777);
        cyc(1, 16'h1000, 1, 0, 0, 0, 1);
        chk("clr_rng", range_err, 1'b0);
        chk("clr_ld", ld_count, 8'd0);
        chk("clr_st", st_count, 8'd0);
        chk("clr_level", level, 4'd1);

        // Saturation, then asynchronous reset inside a capture cycle
        for (int i = 0; i < 300; i++)
            cyc(1, 16'h0010 + 16'(i), 0, 16'(i), 0, 1, 0);
        chk("sat_st", st_count, 8'd255);
        cyc(1, 16'h0500, 0, 16'h4444, 0, 0, 0);
        #1;
        reset = 1'b0;
        #1;
        chk("arst_valid", entry_valid, 1'b0);
        chk("arst_level", level, 4'd0);
        chk("arst_st", st_count, 8'd0);
        chk("arst_ld", ld_count, 8'd0);
        chk("arst_ovf", overflow, 1'b0);
        chk("arst_rng", range_err, 1'b0);
        chk("arst_addr", entry_addr, 16'h0);
        chk("arst_data", entry_data, 16'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        cyc(1, 16'h0500, 0, 16'h4444, 0, 0, 0);
        cyc(1, 16'h0500, 0, 16'h4444, 0, 0, 0);
        chk("post_rst_addr", entry_addr, 16'h0500);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 9) != 0,
                addr_pool[$urandom_range(0, 4)],
                1'($urandom_range(0, 1)),
                16'($urandom),
                16'($urandom),
                $urandom_range(0, 9) < 4,
                $urandom_range(0, 29) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_access_tracer.md
# bus_access_tracer

- Passive monitor on the CPU-to-memory bus (Address, RW, CPU write data, memory read data).
- Detects each load/store access and records it as a trace entry in a small FIFO; the testbench or a debug port drains the FIFO.
- Keeps saturating load/store counters and sticky overflow and out-of-range flags.
- Sits directly downstream of the CPU bus, in parallel with the memory. It never drives the bus.

## Interface
Parameters:
- N, 16, data width
- A, 16, address width
- DEPTH, 8, FIFO entries (power of two, ≥2)
- LIMIT, 4096, first illegal address

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- Address  in  A  CPU bus address
- RW  in  1  1 = read, 0 = write
- wdata  in  N  CPU write data (CPU Dout)
- rdata  in  N  memory read data (memory Dout)
- en  in  1  trace enable
- clear  in  1  synchronous clear of counters and sticky flags
- pop  in  1  dequeue head entry
- entry_valid  out  1  FIFO not empty
- entry_rw  out  1  RW of head entry
- entry_addr  out  A  address of head entry
- entry_data  out  N  data of head entry
- level  out  $clog2(DEPTH)+1  entries held
- ld_count  out  8  read accesses, saturating
- st_count  out  8  write accesses, saturating
- overflow  out  1  sticky: an entry was dropped
- range_err  out  1  sticky: an access hit Address ≥ LIMIT

## Operation
- **Access start (cycle t):** `en`=1 and any of the following:
  - state IDLE,
  - Address ≠ previous-cycle Address,
  - RW ≠ previous-cycle RW.
- Previous Address and RW are registered every cycle regardless of `en`.
- **FSM states:**
  - IDLE: after reset, or while `en`=0.
  - CAPTURE: one cycle, entered at t+1 after any start.
  - HOLD: access unchanged.
- **Transitions:**
  - IDLE→CAPTURE on start.
  - CAPTURE→CAPTURE on a new start in that cycle; otherwise CAPTURE→HOLD.
  - HOLD→CAPTURE on start.
  - Any state→IDLE when `en`=0.
- **At start t:** latch Address and RW. For a write, also latch `wdata`.
- **In CAPTURE (t+1):** for a read, sample `rdata` (memory has one-cycle latency). Push {rw, addr, data} into the FIFO at the end of t+1.
- At most one start per cycle, so there is at most one push per cycle.
- **Counters:**
  - `ld_count`++ on a read start; `st_count`++ on a write start.
  - Both saturate at 255.
  - `clear` zeroes both counters, `overflow` and `range_err`. `clear` wins over a simultaneous increment or set. It does not affect FIFO contents.
- **`range_err`:** set on any start with Address ≥ LIMIT (unsigned compare). The entry is still logged.
- **FIFO:**
  - Head is shown combinationally from registered storage.
  - `pop` with `level`=0 is ignored.
  - Push with `level`=DEPTH and no `pop`: entry dropped, `overflow` set, `level` unchanged.
  - Push and pop together at full: both take effect; `level` stays DEPTH; no overflow.
  - Push and pop together at empty: only the push happens.
  - Read/write pointers wrap modulo DEPTH.
- **`en` falling:**
  - Counters and FIFO hold.
  - A CAPTURE already in progress completes its push.
  - A start cannot occur while `en`=0.

## Timing
- **Reset values:**
  - `entry_valid`=0, `level`=0, `ld_count`=0, `st_count`=0, `overflow`=0, `range_err`=0.
  - `entry_rw`/`entry_addr`/`entry_data` = 0.
  - FSM = IDLE; previous Address = 0 and previous RW = 1.
- **Reset asserted mid-access:** any pending capture is discarded and the FIFO is emptied immediately (asynchronous).
- **Latency:** start in cycle t → push at the edge ending t+1 → `entry_valid`=1 in t+2 (FIFO previously empty).
- Counters and `range_err` update at the edge ending cycle t.
- `pop` is sampled at a rising edge; the next head appears the following cycle.

## Test plan
1. **Single store.**
   - Stimulus: reset, `en`=1, Address=0x0010, RW=0, wdata=0xBEEF held for 3 cycles.
   - Response: exactly one entry {0, 0x0010, 0xBEEF}, `st_count`=1, `entry_valid` two cycles after the start.
2. **Single load.**
   - Stimulus: RW=1, Address=0x0020; `rdata`=0x1234 one cycle later.
   - Response: entry {1, 0x0020, 0x1234}, `ld_count`=1.
3. **Back-to-back accesses.**
   - Stimulus: Address changes every cycle: 0x1, 0x2, 0x3 (reads).
   - Response: 3 entries in order with matching `rdata`, `level`=3.
4. **Overflow and full boundary.**
   - Stimulus: DEPTH+2 starts with no pop.
   - Response: `level`=8, `overflow`=1, FIFO holds the first 8 entries.
   - Follow-up: push+pop together at full → `level` stays 8 and `overflow` is not newly set.
5. **Range and clear.**
   - Stimulus: read at 0x1000.
   - Response: `range_err`=1 and the entry is logged.
   - Follow-up: `clear` → counters and flags go to 0, `level` is unchanged.
6. **Saturation and asynchronous reset.**
   - Stimulus: 300 stores.
   - Response: `st_count`=255.
   - Follow-up: assert `reset` low mid-CAPTURE → all outputs return to reset values without waiting for a clock edge.
